// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type instruction sequencer: FSM states,
// ALU operation codes and the R-type major opcode.
package rtype_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_TRAP      = 3'd5
   } state_t;

   localparam logic [6:0] OPCODE_OP = 7'b0110011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SLT = 4'b0110;
   localparam logic [3:0] ALU_XOR = 4'b0111;

endpackage

// File: rtl/rtype_sequencer_if.sv
// Instruction-fetch handshake between the sequencer (master) and the
// instruction memory (slave).
interface rtype_sequencer_if;

   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, output imem_ack, output imem_rdata);

endinterface

// File: rtl/rtype_decode.sv
// Combinational R-type decoder: maps opcode/func3/func7 to an ALU code and
// a legality flag. Illegal encodings report ALU code 0.
module rtype_decode
   import rtype_pkg::*;
(
   input  logic [6:0] func7_i,
   input  logic [2:0] func3_i,
   input  logic [6:0] opcode_i,
   output logic [3:0] alu_op_o,
   output logic       legal_o
);

   always_comb begin
      alu_op_o = ALU_AND;
      legal_o  = 1'b0;
      if (opcode_i == OPCODE_OP) begin
         if (func7_i == 7'd0) begin
            legal_o = 1'b1;
            case (func3_i)
               3'd0:    alu_op_o = ALU_ADD;
               3'd1:    alu_op_o = ALU_SLL;
               3'd2:    alu_op_o = ALU_SLT;
               3'd4:    alu_op_o = ALU_XOR;
               3'd5:    alu_op_o = ALU_SRL;
               3'd6:    alu_op_o = ALU_OR;
               3'd7:    alu_op_o = ALU_AND;
               default: legal_o  = 1'b0;
            endcase
         end else if (func7_i == 7'd32 && func3_i == 3'd0) begin
            legal_o  = 1'b1;
            alu_op_o = ALU_SUB;
         end
      end
   end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle R-type instruction sequencer: fetch, decode, execute and
// writeback with a sticky trap on illegal encodings.
module rtype_sequencer
   import rtype_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                halt_req,
   rtype_sequencer_if.master   imem,
   output logic [4:0]          rs1,
   output logic [4:0]          rs2,
   output logic [4:0]          rd,
   output logic [3:0]          alu_op,
   output logic                reg_write,
   output logic                pc_inc,
   output logic                busy,
   output logic                illegal_instr,
   output logic [CNT_W-1:0]    retired_cnt
);

   state_t             state_q, state_d;
   logic [31:0]        ir_q, ir_d;
   logic [3:0]         alu_op_q, alu_op_d;
   logic               reg_write_q, reg_write_d;
   logic               pc_inc_q, pc_inc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         dec_alu_op;
   logic               dec_legal;

   rtype_decode u_decode (
      .func7_i  (ir_q[31:25]),
      .func3_i  (ir_q[14:12]),
      .opcode_i (ir_q[6:0]),
      .alu_op_o (dec_alu_op),
      .legal_o  (dec_legal)
   );

   // Strobes are computed in EXECUTE so they appear registered during WRITEBACK.
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      alu_op_d    = alu_op_q;
      reg_write_d = 1'b0;
      pc_inc_d    = 1'b0;
      cnt_d       = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem.imem_ack) begin
               ir_d    = imem.imem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            alu_op_d = dec_alu_op;
            state_d  = dec_legal ? ST_EXECUTE : ST_TRAP;
         end
         ST_EXECUTE: begin
            pc_inc_d    = 1'b1;
            reg_write_d = (ir_q[11:7] != 5'd0);
            state_d     = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = halt_req ? ST_IDLE : ST_FETCH;
         end
         ST_TRAP: begin
            state_d = ST_TRAP;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ir_q        <= '0;
         alu_op_q    <= ALU_AND;
         reg_write_q <= 1'b0;
         pc_inc_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         alu_op_q    <= alu_op_d;
         reg_write_q <= reg_write_d;
         pc_inc_q    <= pc_inc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign imem.imem_req = (state_q == ST_FETCH);
   assign rs1           = ir_q[19:15];
   assign rs2           = ir_q[24:20];
   assign rd            = ir_q[11:7];
   assign alu_op        = alu_op_q;
   assign reg_write     = reg_write_q;
   assign pc_inc        = pc_inc_q;
   assign busy          = (state_q != ST_IDLE);
   assign illegal_instr = (state_q == ST_TRAP);
   assign retired_cnt   = cnt_q;

endmodule

// File: tb/tb_rtype_sequencer.sv
// Self-checking bench for rtype_sequencer: a transaction-level model
// predicts every output each cycle, plus literal checks on key scenarios.
module tb_rtype_sequencer;

   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             start;
   logic             halt_req;
   logic [4:0]       rs1, rs2, rd;
   logic [3:0]       alu_op;
   logic             reg_write, pc_inc, busy, illegal_instr;
   logic [CNT_W-1:0] retired_cnt;

   rtype_sequencer_if bus ();

   rtype_sequencer #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .halt_req      (halt_req),
      .imem          (bus),
      .rs1           (rs1),
      .rs2           (rs2),
      .rd            (rd),
      .alu_op        (alu_op),
      .reg_write     (reg_write),
      .pc_inc        (pc_inc),
      .busy          (busy),
      .illegal_instr (illegal_instr),
      .retired_cnt   (retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU code and legality for func7=0, indexed by func3.
   localparam logic [3:0] F7Z_OP [8] = '{4'h2, 4'h3, 4'h6, 4'h0, 4'h7, 4'h5, 4'h1, 4'h0};
   localparam bit         F7Z_OK [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   int          n_chk = 0;
   int          n_fail = 0;
   int          req_cycles = 0;
   int          pc_pulses = 0;
   int          rw_pulses = 0;

   logic [31:0] m_ir;
   logic [3:0]  m_alu;
   bit          m_alu_known;
   int          m_cnt;
   bit          exp_req, exp_busy, exp_ill, exp_rw, exp_pc;

   function automatic void ref_decode(input logic [31:0] w, output bit legal, output logic [3:0] op);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = w[14:12];
      f7 = w[31:25];
      legal = (w[6:0] == 7'h33) &&
              ((f7 == 7'd0 && F7Z_OK[f3]) || (f7 == 7'd32 && f3 == 3'd0));
      op = (f7 == 7'd32) ? 4'h4 : F7Z_OP[f3];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("imem_req",      32'(bus.imem_req),  32'(exp_req));
      chk("busy",          32'(busy),          32'(exp_busy));
      chk("illegal_instr", 32'(illegal_instr), 32'(exp_ill));
      chk("reg_write",     32'(reg_write),     32'(exp_rw));
      chk("pc_inc",        32'(pc_inc),        32'(exp_pc));
      chk("retired_cnt",   32'(retired_cnt),   32'(m_cnt % (1 << CNT_W)));
      chk("rs1",           32'(rs1),           32'(m_ir[19:15]));
      chk("rs2",           32'(rs2),           32'(m_ir[24:20]));
      chk("rd",            32'(rd),            32'(m_ir[11:7]));
      if (m_alu_known) chk("alu_op", 32'(alu_op), 32'(m_alu));
      if (bus.imem_req) req_cycles++;
      if (pc_inc) pc_pulses++;
      if (reg_write) rw_pulses++;
   endtask

   task automatic cycle();
      @(negedge clk);
      compare();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; reset takes effect at once.
   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      bus.imem_ack = 1'b0;
      exp_req = 0; exp_busy = 0; exp_ill = 0; exp_rw = 0; exp_pc = 0;
      m_ir = '0; m_alu = '0; m_alu_known = 1; m_cnt = 0;
      cycle();
      cycle();
      reset = 1'b0;
      cycle();
   endtask

   task automatic do_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
      exp_req = 1; exp_busy = 1;
   endtask

   // Runs one instruction from FETCH. st: 0 retired, 1 trapped, 2 reset in EXECUTE.
   task automatic run_instr(input logic [31:0] w, input int waits, input bit halt,
                            input bit rst_exec, output int st);
      bit         lg;
      logic [3:0] op;
      for (int i = 0; i < waits; i++) begin
         bus.imem_ack = 1'b0;
         bus.imem_rdata = $urandom;
         halt_req = 1'($urandom);
         cycle();
      end
      bus.imem_ack = 1'b1;
      bus.imem_rdata = w;
      cycle();
      m_ir = w; exp_req = 0;
      bus.imem_ack = 1'($urandom);
      bus.imem_rdata = $urandom;
      start = 1'($urandom);
      cycle();
      ref_decode(w, lg, op);
      bus.imem_ack = 1'($urandom);
      start = 1'($urandom);
      if (!lg) begin
         exp_ill = 1; m_alu_known = 0; st = 1;
         return;
      end
      m_alu = op;
      if (rst_exec) begin
         do_reset();
         st = 2;
         return;
      end
      cycle();
      exp_pc = 1; exp_rw = (w[11:7] != 5'd0);
      halt_req = halt;
      cycle();
      exp_pc = 0; exp_rw = 0; m_cnt++;
      start = 1'b0;
      bus.imem_ack = 1'b0;
      halt_req = 1'($urandom);
      exp_req = !halt; exp_busy = !halt;
      st = 0;
   endtask

   task automatic hold_trap(input int n);
      for (int i = 0; i < n; i++) begin
         start = 1'($urandom);
         bus.imem_ack = 1'($urandom);
         halt_req = 1'($urandom);
         cycle();
      end
   endtask

   function automatic logic [31:0] rand_legal();
      int k;
      logic [31:0] w;
      k = $urandom_range(0, 8);
      w = $urandom;
      w[6:0] = 7'h33;
      if (k == 3 || k == 8) begin
         w[31:25] = 7'd32; w[14:12] = 3'd0;
      end else begin
         w[31:25] = 7'd0;  w[14:12] = 3'(k);
      end
      if ($urandom_range(0, 5) == 0) w[11:7] = 5'd0;
      return w;
   endfunction

   initial begin
      int st, p0, r0, q0;
      bit in_idle;
      logic [31:0] w;
      reset = 1'b1; start = 1'b0; halt_req = 1'b0;
      bus.imem_ack = 1'b0; bus.imem_rdata = '0;
      exp_req = 0; exp_busy = 0; exp_ill = 0; exp_rw = 0; exp_pc = 0;
      m_ir = '0; m_alu = '0; m_alu_known = 1; m_cnt = 0;
      #1;
      do_reset();
      chk("reset_cnt", 32'(retired_cnt), 32'd0);

      // ADD x3,x1,x2 with immediate ack and halt
      p0 = pc_pulses; r0 = rw_pulses;
      do_start();
      run_instr(32'h002081B3, 0, 1'b1, 1'b0, st);
      cycle();
      chk("add_alu", 32'(alu_op), 32'h2);
      chk("add_rd", 32'(rd), 32'd3);
      chk("add_cnt", 32'(retired_cnt), 32'd1);
      chk("add_pc_pulses", 32'(pc_pulses - p0), 32'd1);
      chk("add_rw_pulses", 32'(rw_pulses - r0), 32'd1);

      // SUB with three wait cycles before ack
      q0 = req_cycles;
      do_start();
      run_instr(32'h402081B3, 3, 1'b1, 1'b0, st);
      cycle();
      chk("sub_req_cycles", 32'(req_cycles - q0), 32'd4);
      chk("sub_alu", 32'(alu_op), 32'h4);

      // Illegal opcode traps and holds until reset
      r0 = rw_pulses; p0 = pc_pulses;
      do_start();
      run_instr(32'h00000013, 0, 1'b0, 1'b0, st);
      hold_trap(20);
      chk("ill_flag", 32'(illegal_instr), 32'd1);
      chk("ill_rw_pulses", 32'(rw_pulses - r0), 32'd0);
      chk("ill_pc_pulses", 32'(pc_pulses - p0), 32'd0);
      do_reset();

      // rd=0 retires without a register write
      r0 = rw_pulses; p0 = pc_pulses;
      do_start();
      run_instr(32'h00208033, 1, 1'b1, 1'b0, st);
      cycle();
      chk("rd0_rw_pulses", 32'(rw_pulses - r0), 32'd0);
      chk("rd0_pc_pulses", 32'(pc_pulses - p0), 32'd1);
      chk("rd0_cnt", 32'(retired_cnt), 32'd1);

      // Counter wrap over 17 back-to-back instructions
      do_reset();
      do_start();
      for (int i = 0; i < 17; i++) run_instr(rand_legal(), 0, (i == 16), 1'b0, st);
      cycle();
      chk("wrap_cnt", 32'(retired_cnt), 32'd1);

      // Reset asserted in EXECUTE
      p0 = pc_pulses; r0 = rw_pulses;
      do_start();
      run_instr(32'h002081B3, 0, 1'b0, 1'b1, st);
      cycle();
      chk("rst_pc_pulses", 32'(pc_pulses - p0), 32'd0);
      chk("rst_rw_pulses", 32'(rw_pulses - r0), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // Randomized traffic
      in_idle = 1;
      for (int n = 0; n < 60; n++) begin
         if (in_idle) begin
            for (int i = 0, lim = $urandom_range(0, 2); i < lim; i++) begin
               bus.imem_ack = 1'($urandom);
               halt_req = 1'($urandom);
               cycle();
            end
            bus.imem_ack = 1'b0;
            do_start();
         end
         w = ($urandom_range(0, 6) == 0) ? 32'($urandom) : rand_legal();
         run_instr(w, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 9) == 0), st);
         if (st == 1) begin
            hold_trap($urandom_range(2, 6));
            do_reset();
            in_idle = 1;
         end else if (st == 2) begin
            in_idle = 1;
         end else begin
            in_idle = !exp_busy;
         end
      end
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
